// File: rtl/regfile_pkg.sv
// Shared types, default widths and bus-slicing helper for the multi-port register file.
package regfile_pkg;

    typedef enum logic [1:0] {
        CLR_IDLE,
        CLR_CLEAR,
        CLR_DONE
    } ClrState_t;

    localparam int unsigned RF_W_DATA = 32;
    localparam int unsigned RF_W_ADDR = 5;
    localparam int unsigned RF_NUM_RD = 3;
    localparam int unsigned RF_NUM_WR = 2;

    // Base bit offset of lane idx in a flattened bus of width-bit lanes.
    function automatic int unsigned rf_slice(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks every array index once, zeroing one entry per cycle,
// then pulses ClrDone for one cycle before returning to idle.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int unsigned W_ADDR = RF_W_ADDR
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              ClrReq,
    output logic              ClrBusy,
    output logic              ClrDone,
    output logic              ClrWrEn,
    output logic [W_ADDR-1:0] ClrWrAddr
);

    localparam logic [W_ADDR-1:0] CNT_LAST = '1;

    ClrState_t         state_q, state_d;
    logic [W_ADDR-1:0] cnt_q, cnt_d;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= CLR_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLR_IDLE: begin
                if (ClrReq) begin
                    state_d = CLR_CLEAR;
                    cnt_d   = '0;
                end
            end
            CLR_CLEAR: begin
                // Leave before the counter would wrap.
                if (cnt_q == CNT_LAST) begin
                    state_d = CLR_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CLR_DONE: state_d = CLR_IDLE;
            default:  state_d = CLR_IDLE;
        endcase
    end

    always_comb begin
        ClrBusy   = (state_q != CLR_IDLE);
        ClrDone   = (state_q == CLR_DONE);
        ClrWrEn   = (state_q == CLR_CLEAR);
        ClrWrAddr = cnt_q;
    end

endmodule

// File: rtl/multi_port_register_file.sv
// Multi-port register file with latched read addresses, prioritised write ports,
// a hardwired zero register, optional write-to-read bypass and a clear sequencer.
module multi_port_register_file
    import regfile_pkg::*;
#(
    parameter int unsigned W_DATA   = RF_W_DATA,
    parameter int unsigned W_ADDR   = RF_W_ADDR,
    parameter int unsigned NUM_RD   = RF_NUM_RD,
    parameter int unsigned NUM_WR   = RF_NUM_WR,
    parameter int unsigned ZERO_IDX = (2 ** W_ADDR) - 1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [NUM_RD-1:0]        RdEn,
    input  logic [NUM_RD*W_ADDR-1:0] RdAddr,
    output logic [NUM_RD*W_DATA-1:0] RdData,
    input  logic [NUM_WR-1:0]        WrEn,
    input  logic [NUM_WR*W_ADDR-1:0] WrAddr,
    input  logic [NUM_WR*W_DATA-1:0] WrData,
    input  logic                     ClrReq,
    output logic                     ClrBusy,
    output logic                     ClrDone
);

    localparam int unsigned       DEPTH     = 2 ** W_ADDR;
    localparam logic [W_ADDR-1:0] ZERO_ADDR = W_ADDR'(ZERO_IDX);

    logic [W_DATA-1:0] mem_q [DEPTH];
    logic [W_DATA-1:0] mem_d [DEPTH];
    logic [W_ADDR-1:0] rd_addr_q [NUM_RD];
    logic [W_ADDR-1:0] rd_addr_d [NUM_RD];

    logic [W_ADDR-1:0] wr_addr [NUM_WR];
    logic [W_DATA-1:0] wr_data [NUM_WR];
    logic [NUM_WR-1:0] wr_ok;

    logic              clr_wr_en;
    logic [W_ADDR-1:0] clr_wr_addr;

    regfile_clear_seq #(
        .W_ADDR(W_ADDR)
    ) u_clear_seq (
        .Clock    (Clock),
        .Reset    (Reset),
        .ClrReq   (ClrReq),
        .ClrBusy  (ClrBusy),
        .ClrDone  (ClrDone),
        .ClrWrEn  (clr_wr_en),
        .ClrWrAddr(clr_wr_addr)
    );

    always_comb begin
        for (int unsigned j = 0; j < NUM_WR; j++) begin
            wr_addr[j] = WrAddr[rf_slice(j, W_ADDR) +: W_ADDR];
            wr_data[j] = WrData[rf_slice(j, W_DATA) +: W_DATA];
            wr_ok[j]   = WrEn[j] && !ClrBusy && (wr_addr[j] != ZERO_ADDR);
        end
    end

    // Later write ports overwrite earlier ones, so the highest port wins a conflict.
    always_comb begin
        mem_d = mem_q;
        for (int unsigned j = 0; j < NUM_WR; j++) begin
            if (wr_ok[j]) begin
                mem_d[wr_addr[j]] = wr_data[j];
            end
        end
        if (clr_wr_en) begin
            mem_d[clr_wr_addr] = '0;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            rd_addr_d[i] = RdEn[i] ? RdAddr[rf_slice(i, W_ADDR) +: W_ADDR] : rd_addr_q[i];
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
            for (int unsigned i = 0; i < NUM_RD; i++) begin
                rd_addr_q[i] <= '0;
            end
        end else begin
            mem_q     <= mem_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [W_DATA-1:0] rd_val;

        always_comb begin
            rd_val = mem_q[rd_addr_q[i]];
            if (BYPASS) begin
                for (int unsigned j = 0; j < NUM_WR; j++) begin
                    if (wr_ok[j] && (wr_addr[j] == rd_addr_q[i])) begin
                        rd_val = wr_data[j];
                    end
                end
                if (clr_wr_en && (clr_wr_addr == rd_addr_q[i])) begin
                    rd_val = '0;
                end
            end
            if (rd_addr_q[i] == ZERO_ADDR) begin
                rd_val = '0;
            end
        end

        assign RdData[i*W_DATA +: W_DATA] = rd_val;
    end

endmodule

// File: tb/tb_multi_port_register_file.sv
// Randomised and directed bench for multi_port_register_file, comparing a bypass and a
// non-bypass instance against an array-based reference model every cycle.
module tb_multi_port_register_file;

    localparam int W_DATA = 32;
    localparam int W_ADDR = 5;
    localparam int NUM_RD = 3;
    localparam int NUM_WR = 2;
    localparam int DEPTH  = 32;
    localparam int ZIDX   = 31;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*W_ADDR-1:0] rd_addr;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*W_ADDR-1:0] wr_addr;
    logic [NUM_WR*W_DATA-1:0] wr_data;
    logic                     clr_req;
    logic [NUM_RD*W_DATA-1:0] rd_data_b, rd_data_nb;
    logic                     busy_b, done_b, busy_nb, done_nb;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] m_mem [DEPTH];
    int          m_raddr [NUM_RD];
    int          m_phase;
    logic        s_busy, s_done;

    always #5 clk = ~clk;

    multi_port_register_file #(
        .W_DATA(W_DATA), .W_ADDR(W_ADDR), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR),
        .ZERO_IDX(ZIDX), .BYPASS(1'b1)
    ) dut (
        .Clock(clk), .Reset(rst), .RdEn(rd_en), .RdAddr(rd_addr), .RdData(rd_data_b),
        .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data), .ClrReq(clr_req),
        .ClrBusy(busy_b), .ClrDone(done_b)
    );

    multi_port_register_file #(
        .W_DATA(W_DATA), .W_ADDR(W_ADDR), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR),
        .ZERO_IDX(ZIDX), .BYPASS(1'b0)
    ) dut_nb (
        .Clock(clk), .Reset(rst), .RdEn(rd_en), .RdAddr(rd_addr), .RdData(rd_data_nb),
        .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data), .ClrReq(clr_req),
        .ClrBusy(busy_nb), .ClrDone(done_nb)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] exp_rd(input int p, input bit byp);
        int          a;
        logic [31:0] v;
        a = m_raddr[p];
        v = m_mem[a];
        if (a == ZIDX) return 32'h0;
        if (byp) begin
            if (m_phase >= 0 && m_phase < DEPTH) begin
                if (m_phase == a) v = 32'h0;
            end else if (m_phase < 0) begin
                for (int j = 0; j < NUM_WR; j++)
                    if (wr_en[j] && int'(wr_addr[j*W_ADDR +: W_ADDR]) == a)
                        v = wr_data[j*W_DATA +: W_DATA];
            end
        end
        return v;
    endfunction

    task automatic model_update();
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) m_mem[k] = 32'h0;
            for (int p = 0; p < NUM_RD; p++) m_raddr[p] = 0;
            m_phase = -1;
        end else begin
            if (m_phase >= 0 && m_phase < DEPTH) begin
                m_mem[m_phase] = 32'h0;
            end else if (m_phase < 0) begin
                for (int j = 0; j < NUM_WR; j++)
                    if (wr_en[j] && int'(wr_addr[j*W_ADDR +: W_ADDR]) != ZIDX)
                        m_mem[wr_addr[j*W_ADDR +: W_ADDR]] = wr_data[j*W_DATA +: W_DATA];
            end
            for (int p = 0; p < NUM_RD; p++)
                if (rd_en[p]) m_raddr[p] = int'(rd_addr[p*W_ADDR +: W_ADDR]);
            if (m_phase < 0) begin
                if (clr_req) m_phase = 0;
            end else if (m_phase == DEPTH) begin
                m_phase = -1;
            end else begin
                m_phase++;
            end
        end
    endtask

    // Inputs are driven just after the falling edge; outputs are compared before the rising edge.
    task automatic cycle();
        #2;
        for (int p = 0; p < NUM_RD; p++) begin
            check($sformatf("rd%0d_byp", p), rd_data_b[p*W_DATA +: W_DATA], exp_rd(p, 1'b1));
            check($sformatf("rd%0d_nobyp", p), rd_data_nb[p*W_DATA +: W_DATA], exp_rd(p, 1'b0));
        end
        check("busy", {31'b0, busy_b}, {31'b0, m_phase >= 0});
        check("done", {31'b0, done_b}, {31'b0, m_phase == DEPTH});
        check("busy_nb", {31'b0, busy_nb}, {31'b0, m_phase >= 0});
        check("done_nb", {31'b0, done_nb}, {31'b0, m_phase == DEPTH});
        s_busy = busy_b;
        s_done = done_b;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 1'b0; rd_en = '0; wr_en = '0; clr_req = 1'b0;
    endtask

    task automatic set_wr(input int j, input int a, input logic [31:0] d);
        wr_en[j] = 1'b1;
        wr_addr[j*W_ADDR +: W_ADDR] = W_ADDR'(a);
        wr_data[j*W_DATA +: W_DATA] = d;
    endtask

    task automatic set_rd(input int p, input int a);
        rd_en[p] = 1'b1;
        rd_addr[p*W_ADDR +: W_ADDR] = W_ADDR'(a);
    endtask

    task automatic probe(input string tag, input int p, input logic [31:0] eb, input logic [31:0] enb);
        #1;
        check({tag, "_byp"}, rd_data_b[p*W_DATA +: W_DATA], eb);
        check({tag, "_nobyp"}, rd_data_nb[p*W_DATA +: W_DATA], enb);
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;
        rd_addr = '0; wr_addr = '0; wr_data = '0;
        idle();
        rst = 1'b1;
        @(posedge clk);
        model_update();
        @(negedge clk);
        idle();

        // T1 reset
        set_wr(0, 3, 32'hDEAD_BEEF); cycle(); idle();
        rst = 1'b1; cycle(); idle();
        for (int p = 0; p < NUM_RD; p++) set_rd(p, 3);
        cycle(); idle();
        for (int p = 0; p < NUM_RD; p++) probe($sformatf("t1_rd%0d", p), p, 32'h0, 32'h0);
        #1 check("t1_busy", {31'b0, busy_b}, 32'h0);
        cycle();

        // T2 zero register
        set_wr(0, 31, 32'h1234);
        for (int p = 0; p < NUM_RD; p++) set_rd(p, 31);
        cycle(); idle();
        set_wr(0, 31, 32'h1234);
        probe("t2_zero", 0, 32'h0, 32'h0);
        cycle(); idle();

        // T3 write conflict
        set_wr(0, 5, 32'h11); set_wr(1, 5, 32'h22); cycle(); idle();
        set_rd(0, 5); cycle(); idle();
        probe("t3_r5", 0, 32'h22, 32'h22);
        cycle();

        // T4 bypass
        set_wr(0, 7, 32'hA); cycle(); idle();
        set_rd(2, 7); cycle(); idle();
        set_wr(1, 7, 32'hB);
        probe("t4_same", 2, 32'hB, 32'hA);
        cycle(); idle();
        probe("t4_after", 2, 32'hB, 32'hB);
        cycle();

        // T5 clear
        for (int k = 0; k < 31; k += 2) begin
            set_wr(0, k, k);
            if (k + 1 < 31) set_wr(1, k + 1, k + 1);
            cycle(); idle();
        end
        clr_req = 1'b1; cycle(); idle();
        busy_cnt = 0; done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (c < 20) set_wr(0, 4, 32'hFFFF);
            set_rd(c % NUM_RD, $urandom_range(0, 31));
            cycle(); idle();
            if (s_busy) busy_cnt++;
            if (s_done) begin
                done_cnt++;
                check("t5_done_pos", c, 32);
            end
        end
        check("t5_busy_cycles", busy_cnt, 33);
        check("t5_done_pulses", done_cnt, 1);
        for (int k = 0; k < DEPTH; k += NUM_RD) begin
            for (int p = 0; p < NUM_RD; p++) set_rd(p, (k + p) % DEPTH);
            cycle(); idle();
        end
        set_rd(0, 4); cycle(); idle();
        probe("t5_r4", 0, 32'h0, 32'h0);
        cycle();

        // T6 reset mid-clear
        for (int k = 1; k < 8; k++) begin set_wr(0, k, 32'h100 + k); cycle(); idle(); end
        clr_req = 1'b1; cycle(); idle();
        for (int c = 0; c < 10; c++) cycle();
        rst = 1'b1; cycle(); idle();
        #1 check("t6_busy_after_rst", {31'b0, busy_b}, 32'h0);
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            cycle();
            if (s_done) done_cnt++;
        end
        check("t6_no_done", done_cnt, 0);
        clr_req = 1'b1; cycle(); idle();
        #1 check("t6_reaccept", {31'b0, busy_b}, 32'h1);
        for (int c = 0; c < 34; c++) cycle();

        // Random traffic, addresses biased towards a small range to provoke collisions
        for (int c = 0; c < 400; c++) begin
            idle();
            rst     = ($urandom_range(0, 199) == 0);
            clr_req = ($urandom_range(0, 39) == 0);
            for (int p = 0; p < NUM_RD; p++)
                if ($urandom_range(0, 1) == 1)
                    set_rd(p, ($urandom_range(0, 9) == 0) ? 31 : $urandom_range(0, 7));
            for (int j = 0; j < NUM_WR; j++)
                if ($urandom_range(0, 2) != 0)
                    set_wr(j, ($urandom_range(0, 9) == 0) ? 31 : $urandom_range(0, 7), $urandom);
            cycle();
        end
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
